// File: rtl/ram_arbiter.sv
// Two-port arbiter sharing one single-port synchronous RAM between the CPU (A)
// and a loader/debug master (B). Round-robin arbitration with a bounded lock
// that lets B run back-to-back bursts; read data is steered to the issuer.
module ram_arbiter #(
  parameter int unsigned DWIDTH   = 16,
  parameter int unsigned AWIDTH   = 12,
  parameter int unsigned LOCK_MAX = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_req_i,
  input  logic              a_we_i,
  input  logic [AWIDTH-1:0] a_addr_i,
  input  logic [DWIDTH-1:0] a_wdata_i,
  output logic              a_gnt_o,
  output logic              a_rvalid_o,
  output logic [DWIDTH-1:0] a_rdata_o,
  input  logic              b_req_i,
  input  logic              b_we_i,
  input  logic [AWIDTH-1:0] b_addr_i,
  input  logic [DWIDTH-1:0] b_wdata_i,
  input  logic              b_lock_i,
  output logic              b_gnt_o,
  output logic              b_rvalid_o,
  output logic [DWIDTH-1:0] b_rdata_o,
  output logic              ram_load_o,
  output logic [AWIDTH-1:0] ram_addr_o,
  output logic [DWIDTH-1:0] ram_d_o,
  input  logic [DWIDTH-1:0] ram_q_i
);

  localparam logic [7:0] LockMax = 8'(LOCK_MAX);

  typedef enum logic {PortA = 1'b0, PortB = 1'b1} port_e;

  port_e       last_q, last_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic [1:0]  rd_owner_q, rd_owner_d;  // bit 0 = A, bit 1 = B
  logic        gnt_a, gnt_b;
  logic        b_lock_win;

  // Grant decision; reset forces both grants low so nothing reaches the RAM.
  always_comb begin
    gnt_a      = 1'b0;
    gnt_b      = 1'b0;
    b_lock_win = b_lock_i && (last_q == PortB) && (lock_cnt_q < LockMax);
    if (rst_ni) begin
      if (a_req_i && !b_req_i) begin
        gnt_a = 1'b1;
      end else if (b_req_i && !a_req_i) begin
        gnt_b = 1'b1;
      end else if (a_req_i && b_req_i) begin
        if (b_lock_win || (last_q == PortA)) begin
          gnt_b = 1'b1;
        end else begin
          gnt_a = 1'b1;
        end
      end
    end
  end

  // RAM pin steering; an ungranted cycle issues a harmless read of A's address.
  always_comb begin
    ram_load_o = 1'b0;
    ram_addr_o = a_addr_i;
    ram_d_o    = a_wdata_i;
    if (gnt_b) begin
      ram_load_o = b_we_i;
      ram_addr_o = b_addr_i;
      ram_d_o    = b_wdata_i;
    end else if (gnt_a) begin
      ram_load_o = a_we_i;
    end
  end

  // Next-state for arbitration history, lock budget and read ownership.
  always_comb begin
    last_d     = last_q;
    lock_cnt_d = lock_cnt_q;
    rd_owner_d = {gnt_b & ~b_we_i, gnt_a & ~a_we_i};
    if (gnt_a) begin
      last_d     = PortA;
      lock_cnt_d = 8'd0;
    end else if (gnt_b) begin
      last_d = PortB;
      if (!b_lock_i) begin
        lock_cnt_d = 8'd0;
      end else if (a_req_i && (lock_cnt_q < LockMax)) begin
        // Only contended locked grants consume the budget.
        lock_cnt_d = lock_cnt_q + 8'd1;
      end
    end
  end

  // State registers; B as reset "last" so A wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q     <= PortB;
      lock_cnt_q <= 8'd0;
      rd_owner_q <= 2'b00;
    end else begin
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
      rd_owner_q <= rd_owner_d;
    end
  end

  // Outputs: both ports see the RAM data, qualified by their own rvalid.
  always_comb begin
    a_gnt_o    = gnt_a;
    b_gnt_o    = gnt_b;
    a_rvalid_o = rd_owner_q[0];
    b_rvalid_o = rd_owner_q[1];
    a_rdata_o  = ram_q_i;
    b_rdata_o  = ram_q_i;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, reference arbitration model feeding
// a read-return scoreboard, directed scenarios, then randomized traffic.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LM = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req = 0, a_we = 0, b_req = 0, b_we = 0, b_lock = 0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid, ram_load;
  logic [DW-1:0] a_rdata, b_rdata, ram_d, ram_q;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  ram_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .LOCK_MAX(LM)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
    .a_gnt_o(a_gnt), .a_rvalid_o(a_rvalid), .a_rdata_o(a_rdata),
    .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
    .b_lock_i(b_lock), .b_gnt_o(b_gnt), .b_rvalid_o(b_rvalid), .b_rdata_o(b_rdata),
    .ram_load_o(ram_load), .ram_addr_o(ram_addr), .ram_d_o(ram_d), .ram_q_i(ram_q)
  );

  // Behavioural single-port RAM, preloaded with a known pattern.
  logic [DW-1:0] tb_mem [4096];
  bit            mem_ready = 0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) tb_mem[i] <= DW'(i * 7);
      mem_ready <= 1'b1;
    end else begin
      ram_q <= tb_mem[ram_addr];
      if (ram_load) tb_mem[ram_addr] <= ram_d;
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    bit            port_b;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb[$];

  // Reference model: which port should win, what the RAM must see, and what
  // read data each granted read must return one cycle later.
  logic [DW-1:0] ref_mem [4096];
  bit            m_last_b = 1;   // last winner was B
  int            m_streak = 0;   // contended locked grants B has taken in a row
  always @(negedge clk) begin : model
    bit  ea, eb;
    rd_t e;
    ea = 0;
    eb = 0;
    if (!rst_n) begin
      chk("a_gnt in reset", a_gnt, 0);
      chk("b_gnt in reset", b_gnt, 0);
      chk("ram_load in reset", ram_load, 0);
      m_last_b = 1;
      m_streak = 0;
    end else begin
      if (a_req && b_req) begin
        if (b_lock && m_last_b && m_streak < LM) eb = 1;
        else if (m_last_b) ea = 1;
        else eb = 1;
      end else begin
        ea = a_req;
        eb = b_req;
      end
      chk("a_gnt", a_gnt, ea);
      chk("b_gnt", b_gnt, eb);
      if (ea) begin
        chk("ram_load A", ram_load, a_we);
        chk("ram_addr A", ram_addr, a_addr);
        if (a_we) begin
          chk("ram_d A", ram_d, a_wdata);
          ref_mem[a_addr] = a_wdata;
        end else begin
          e.cyc = cyc; e.port_b = 0; e.data = ref_mem[a_addr];
          sb.push_back(e);
        end
        m_last_b = 0;
        m_streak = 0;
      end else if (eb) begin
        chk("ram_load B", ram_load, b_we);
        chk("ram_addr B", ram_addr, b_addr);
        if (b_we) begin
          chk("ram_d B", ram_d, b_wdata);
          ref_mem[b_addr] = b_wdata;
        end else begin
          e.cyc = cyc; e.port_b = 1; e.data = ref_mem[b_addr];
          sb.push_back(e);
        end
        m_last_b = 1;
        if (!b_lock) m_streak = 0;
        else if (a_req && m_streak < LM) m_streak = m_streak + 1;
      end else begin
        chk("ram_load idle", ram_load, 0);
        chk("ram_addr idle", ram_addr, a_addr);
      end
    end
  end

  // Monitor: pops the read issued last cycle and checks the returned data.
  always @(negedge clk) begin : monitor
    bit            xa, xb;
    logic [DW-1:0] xd;
    rd_t           e;
    xa = 0;
    xb = 0;
    xd = '0;
    if (!rst_n) begin
      chk("a_rvalid in reset", a_rvalid, 0);
      chk("b_rvalid in reset", b_rvalid, 0);
      sb.delete();
    end else begin
      while (sb.size() > 0 && sb[0].cyc < cyc - 1) begin
        e = sb.pop_front();
        chk("stale read entry", 32'(e.cyc), 32'(cyc - 1));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc - 1) begin
        e  = sb.pop_front();
        xa = !e.port_b;
        xb = e.port_b;
        xd = e.data;
      end
      chk("a_rvalid", a_rvalid, xa);
      chk("b_rvalid", b_rvalid, xb);
      if (xa && a_rvalid) chk("a_rdata", a_rdata, xd);
      if (xb && b_rvalid) chk("b_rdata", b_rdata, xd);
    end
  end

  // One clock of stimulus; returns the grants seen mid-cycle.
  task automatic do_cycle(input logic ar, input logic aw, input logic [AW-1:0] aa,
                          input logic [DW-1:0] ad, input logic br, input logic bw,
                          input logic bl, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                          output logic ga, output logic gb);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_lock = bl; b_addr = ba; b_wdata = bd;
    @(negedge clk);
    ga = a_gnt;
    gb = b_gnt;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 0; b_req = 0; b_lock = 0;
    rst_n = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  initial begin : stim
    logic          ga, gb;
    logic          ap, aw, bp, bw, bl;
    logic [AW-1:0] aa, ba;
    logic [DW-1:0] ad, bd;
    int            bi, run, k;
    bit            seen_a;

    for (int i = 0; i < 4096; i++) ref_mem[i] = DW'(i * 7);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // Single-port write then read on A.
    do_cycle(1, 1, 12'h000, 16'hD000, 0, 0, 0, 12'h000, 16'h0, ga, gb);
    chk("single write a_gnt", ga, 1);
    do_cycle(1, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);
    chk("single read a_gnt", ga, 1);
    do_cycle(0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);

    // Round-robin from reset: A, B, A, B.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      do_cycle(1, 0, 12'h001, 16'h0, 1, 0, 0, 12'h005, 16'h0, ga, gb);
      chk("rr a_gnt", ga, (i % 2 == 0));
      chk("rr b_gnt", gb, (i % 2 == 1));
    end
    do_cycle(0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);

    // Locked B burst with A contending from the second cycle.
    do_reset();
    bi = 0; run = 0; k = 0; seen_a = 0;
    while (bi < 16 && k < 64) begin
      do_cycle(k >= 1, 0, 12'h020, 16'h0, 1, 1, 1, AW'(bi), DW'(16'hB000 + bi), ga, gb);
      if (gb) begin
        if (!seen_a && k > 0) run++;
        bi++;
      end
      if (ga) seen_a = 1;
      k++;
    end
    chk("burst locked run", 32'(run), LM);
    chk("burst A served", seen_a, 1);
    chk("burst finished", 32'(bi), 16);
    do_cycle(0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);
    for (int i = 0; i < 16; i++) chk("burst ram word", tb_mem[i], DW'(16'hB000 + i));

    // Uncontended locked writes are all granted back-to-back.
    for (int i = 0; i < 20; i++) begin
      do_cycle(0, 0, 12'h000, 16'h0, 1, 1, 1, AW'(12'h100 + i), DW'(i), ga, gb);
      chk("uncontended b_gnt", gb, 1);
    end
    do_cycle(1, 0, 12'h100, 16'h0, 1, 1, 0, 12'h140, 16'h1234, ga, gb);
    chk("unlock a_gnt", ga, 1);
    do_cycle(0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);

    // Reset in the cycle a B read returns.
    do_reset();
    do_cycle(0, 0, 12'h000, 16'h0, 1, 0, 0, 12'h005, 16'h0, ga, gb);
    chk("rst b read gnt", gb, 1);
    chk("b_rvalid before reset", b_rvalid, 1);
    a_req = 1; a_we = 0; a_addr = 12'h001;
    b_req = 1; b_we = 0; b_addr = 12'h005; b_lock = 0;
    #2;
    rst_n = 0;
    #1;
    chk("b_rvalid async clear", b_rvalid, 0);
    chk("a_gnt async", a_gnt, 0);
    chk("b_gnt async", b_gnt, 0);
    chk("ram_load async", ram_load, 0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1;
    do_cycle(1, 0, 12'h001, 16'h0, 1, 0, 0, 12'h005, 16'h0, ga, gb);
    chk("post reset a wins", ga, 1);
    chk("post reset b loses", gb, 0);

    // Random traffic; each requester holds its request until granted.
    ap = 0; bp = 0; aw = 0; bw = 0; bl = 0;
    aa = '0; ba = '0; ad = '0; bd = '0;
    for (int i = 0; i < 1500; i++) begin
      if (!ap && $urandom_range(0, 99) < 60) begin
        ap = 1; aw = 1'($urandom_range(0, 1));
        aa = AW'($urandom_range(0, 15)); ad = DW'($urandom);
      end
      if (!bp && $urandom_range(0, 99) < 60) begin
        bp = 1; bw = 1'($urandom_range(0, 1)); bl = ($urandom_range(0, 99) < 50);
        ba = AW'($urandom_range(0, 15)); bd = DW'($urandom);
      end
      do_cycle(ap, aw, aa, ad, bp, bw, bl, ba, bd, ga, gb);
      if (ga) ap = 0;
      if (gb) bp = 0;
    end
    repeat (3) do_cycle(0, 0, 12'h000, 16'h0, 0, 0, 0, 12'h000, 16'h0, ga, gb);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port synchronous 16-bit × 4096-word program/data RAM between the CPU (port A) and a program loader/debug master (port B). It accepts at most one access per cycle and drives the RAM `load`/`addr`/`d` pins. It steers the RAM's one-cycle-latency read data back to whichever requester issued the read. Arbitration is round-robin, with a bounded lock that lets port B perform back-to-back burst loads.

## Interface

Parameters:
- DWIDTH, 16, data width; must match the RAM.
- AWIDTH, 12, address width; must match the RAM.
- LOCK_MAX, 8, maximum consecutive locked grants to B while A is waiting; range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a_req  in  1  port A access request, level.
- a_we  in  1  port A write enable; 1 = write, 0 = read.
- a_addr  in  AWIDTH  port A word address.
- a_wdata  in  DWIDTH  port A write data.
- a_gnt  out  1  port A access accepted this cycle (combinational).
- a_rvalid  out  1  port A read data valid (registered pulse).
- a_rdata  out  DWIDTH  port A read data.
- b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as the A equivalents, for port B.
- b_lock  in  1  port B requests priority for consecutive accesses.
- ram_load  out  1  RAM write strobe.
- ram_addr  out  AWIDTH  RAM address.
- ram_d  out  DWIDTH  RAM write data.
- ram_q  in  DWIDTH  RAM registered read data.

## Operation

State registers:
- last: last granted port. Reset value B, so A wins the first conflict.
- lock_cnt: 8-bit count of consecutive locked grants to B. Reset value 0.
- rd_owner: 2-bit, one bit per port; marks whose read is in flight. Reset value 00.

Grant rules, evaluated combinationally each cycle:
- Only one request: that port is granted.
- Both request, B lock active (b_lock=1, last=B, lock_cnt<LOCK_MAX): B is granted.
- Both request, otherwise: the port not equal to last is granted.
- At most one gnt is high in any cycle. No request means no grant.
- While rst_n=0, both gnt outputs are 0 and ram_load=0.

RAM steering:
- Granted port's we, addr and wdata drive ram_load, ram_addr and ram_d.
- No grant: ram_load=0, ram_addr=a_addr, ram_d=a_wdata. The resulting read is harmless.
- The write path is never asserted without a grant.

Register updates on each clock edge where a grant occurs:
- last is set to the granted port.
- lock_cnt:
  - Increments, saturating at LOCK_MAX, when B is granted with b_lock=1 while a_req=1.
  - Clears to 0 when A is granted, or when B is granted with b_lock=0.
  - Holds when B is granted with b_lock=1 while a_req=0, so an uncontended burst never exhausts the budget.
- Once lock_cnt reaches LOCK_MAX with A waiting, the next conflict grants A. This bounds A's wait to LOCK_MAX cycles.

Read return:
- rd_owner is loaded every cycle with the granted-read one-hot, or 00 if there was no granted read.
- a_rvalid = rd_owner[A], b_rvalid = rd_owner[B].
- a_rdata and b_rdata both equal ram_q; each is meaningful only when its rvalid is high.

Writes:
- A granted write produces no rvalid.
- The RAM's read-during-write data is not returned.

## Timing

- Grant latency: 0 cycles. A request presented in cycle N is granted in cycle N if it wins arbitration.
- A requester holds req, we, addr and wdata stable until it sees gnt.
- The RAM samples the access on the edge that ends cycle N.
- Read data: xx_rvalid is high in cycle N+1 for exactly one cycle, with ram_q valid. Reads are fully pipelined, so one new read per cycle is allowed.
- Write then read of the same address in consecutive cycles (any ports): the read returns the new data in cycle N+2.
- Reset asserted mid-operation: takes effect immediately (asynchronous).
  - rvalid outputs drop to 0 and any in-flight read is discarded.
  - last returns to B and lock_cnt to 0.
  - After release, the first grant can occur in the first cycle rst_n=1.
- Reset values of registered outputs: a_rvalid=0, b_rvalid=0.

## Test plan

- **Single-port read:** after reset, A writes 16'hD000 to 12'h000, then reads it.
  - a_gnt is high in the same cycle as each request.
  - a_rvalid is high one cycle after the read, with a_rdata=16'hD000.
  - b_rvalid stays 0 throughout.
- **Round-robin conflict:** both ports read continuously (A at 12'h001, B at 12'h005) with b_lock=0.
  - Grants go A, B, A, B starting from reset.
  - Each rvalid arrives on its owner one cycle after its grant, never both in the same cycle.
- **Locked burst bound:** LOCK_MAX=8; B issues a write burst with b_lock=1 to addresses 12'h000..12'h00F; A requests continuously from the second cycle.
  - After B's first grant, B gets exactly 8 further consecutive grants.
  - A is then granted, and B resumes its locked burst.
  - The RAM holds all 16 B words.
- **Uncontended lock:** B issues 20 locked writes with a_req=0.
  - All 20 are granted back-to-back and lock_cnt stays 0.
  - A then requests, and a_gnt is high in the first contended cycle in which b_lock=0.
- **Reset mid-read:** B read granted in cycle N; rst_n is pulsed low in cycle N+1 before the edge.
  - b_rvalid is forced to 0 immediately.
  - No gnt and no ram_load while rst_n=0.
  - After release, A wins the first conflict.
